// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game controller.
// Keeps the working board, cursor, turn and result, and publishes
// frame-synchronised shadow copies of the board and highlight mask for
// the renderer. States: PLAY (take input), CHECK (one-cycle line
// evaluation after a placement), OVER (result shown, only new_game works).
// Optional build macro: TTT_ALT_START_EN -- alternate the starting player
// on every new game instead of always starting with player1.
module ttt_game_ctrl #(
    parameter int START_CELL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    input  logic        new_game,
    input  logic        frame_start,
    output logic [17:0] disp_board,
    output logic [8:0]  disp_select,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    // Cell triples for the 8 lines, listed in tie-break order:
    // rows, columns, main diagonal, anti-diagonal.
    localparam int LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    localparam logic [3:0] START = 4'(START_CELL);

    state_t      state;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic [8:0]  win_mask;
`ifdef TTT_ALT_START_EN
    logic        start_player;
`endif

    logic [3:0]  cur_up, cur_down, cur_left, cur_right;
    logic [1:0]  col;
    logic        cell_empty;
    logic        win_found;
    logic [8:0]  win_line;
    logic        board_full;
    logic [8:0]  highlight;
    logic [1:0]  mover_code;

    // Wrap-around neighbours of the cursor within its row / column.
    always_comb begin
        col       = 2'(cursor % 4'd3);
        cur_up    = (cursor >= 4'd3) ? cursor - 4'd3 : cursor + 4'd6;
        cur_down  = (cursor <= 4'd5) ? cursor + 4'd3 : cursor - 4'd6;
        cur_left  = (col == 2'd0)    ? cursor + 4'd2 : cursor - 4'd1;
        cur_right = (col == 2'd2)    ? cursor - 4'd2 : cursor + 4'd1;
    end

    // Placement target, mover code and renderer highlight source.
    always_comb begin
        cell_empty = (board[{cursor, 1'b0} +: 2] == 2'b00);
        mover_code = turn ? 2'b10 : 2'b01;
        highlight  = (state == OVER) ? win_mask : (9'd1 << cursor);
    end

    // Line evaluation; scanning from the last line down lets the
    // lowest-numbered completed line win a tie.
    always_comb begin
        win_found  = 1'b0;
        win_line   = '0;
        board_full = 1'b1;
        for (int c = 0; c < 9; c++)
            board_full = board_full & (|board[2*c +: 2]);
        for (int i = 7; i >= 0; i--) begin
            if (board[2*LINES[i][0] +: 2] != 2'b00 &&
                board[2*LINES[i][0] +: 2] == board[2*LINES[i][1] +: 2] &&
                board[2*LINES[i][0] +: 2] == board[2*LINES[i][2] +: 2]) begin
                win_found = 1'b1;
                win_line  = '0;
                win_line[LINES[i][0]] = 1'b1;
                win_line[LINES[i][1]] = 1'b1;
                win_line[LINES[i][2]] = 1'b1;
            end
        end
    end

    // Game FSM, working registers and frame-synchronised shadows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PLAY;
            board       <= '0;
            cursor      <= START;
            turn        <= 1'b0;
            winner      <= 2'b00;
            win_mask    <= '0;
            game_over   <= 1'b0;
            disp_board  <= '0;
            disp_select <= '0;
`ifdef TTT_ALT_START_EN
            start_player <= 1'b0;
`endif
        end else begin
            // Shadows take the pre-edge working values.
            if (frame_start) begin
                disp_board  <= board;
                disp_select <= highlight;
            end
            if (new_game) begin
                state     <= PLAY;
                board     <= '0;
                cursor    <= START;
                winner    <= 2'b00;
                win_mask  <= '0;
                game_over <= 1'b0;
`ifdef TTT_ALT_START_EN
                start_player <= ~start_player;
                turn         <= ~start_player;
`else
                turn         <= 1'b0;
`endif
            end else begin
                case (state)
                    PLAY: begin
                        if (btn_place) begin
                            if (cell_empty) begin
                                board[{cursor, 1'b0} +: 2] <= mover_code;
                                state <= CHECK;
                            end
                        end else if (btn_up)    cursor <= cur_up;
                        else if (btn_down)      cursor <= cur_down;
                        else if (btn_left)      cursor <= cur_left;
                        else if (btn_right)     cursor <= cur_right;
                    end
                    CHECK: begin
                        if (win_found) begin
                            winner    <= mover_code;
                            win_mask  <= win_line;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (board_full) begin
                            winner    <= 2'b11;
                            win_mask  <= '0;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= PLAY;
                        end
                    end
                    OVER: ;
                    default: state <= PLAY;
                endcase
            end
        end
    end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have parameter START_CELL, default 4, meaning the cursor cell index (0..8, row-major: index = row*3+col) after reset and after each new game.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_up / btn_down / btn_left / btn_right / btn_place  input  1 each  single-cycle pulses from the debouncer.
REQ-005 SHALL have port new_game  input  1  single-cycle pulse that requests a cleared board.
REQ-006 SHALL have port frame_start  input  1  single-cycle pulse at the start of each video frame.
REQ-007 SHALL have port disp_board  output  18  2 bits per cell, cell i at bits [2i+1:2i]; 00 empty, 01 player1, 10 player2.
REQ-008 SHALL have port disp_select  output  9  per-cell highlight mask for the renderer.
REQ-009 SHALL have port turn  output  1  player to move; 0 = player1, 1 = player2.
REQ-010 SHALL have port game_over  output  1  high while in OVER.
REQ-011 SHALL have port winner  output  2  00 none, 01 player1, 10 player2, 11 draw.

Function
REQ-012 SHALL implement FSM states PLAY, CHECK, OVER, with PLAY entered from reset.
REQ-013 In PLAY, button pulses SHALL move the cursor one cell with wrap-around within the row (left from col 0 goes to col 2; right from col 2 goes to col 0) or within the column (up from row 0 goes to row 2; down from row 2 goes to row 0).
REQ-014 Simultaneous pulses SHALL be resolved with one action per cycle, priority new_game > btn_place > up > down > left > right; all lower-priority pulses are dropped.
REQ-015 btn_place on an empty cursor cell SHALL write the mover's code (01/10) into the working board on the next edge and enter CHECK; on an occupied cell it SHALL be ignored and the FSM SHALL stay in PLAY.
REQ-016 CHECK SHALL last exactly one cycle and evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) for three equal non-zero codes.
REQ-017 On a win, CHECK SHALL go to OVER with winner set to the mover's code and a 9-bit win mask holding the completed line; if two lines complete at once, the lowest-numbered line (rows 0-2, then columns 0-2, then diagonal 0-4-8, then diagonal 2-4-6) SHALL be used.
REQ-018 With no win and all 9 cells occupied, CHECK SHALL go to OVER with winner 11 and win mask 0; otherwise CHECK SHALL toggle turn and return to PLAY.
REQ-019 In OVER, all buttons SHALL be ignored except new_game.
REQ-020 new_game in any state SHALL, on the next edge, clear the board, set cursor to START_CELL, clear winner and the win mask, set turn to the starting player (REQ-028), and enter PLAY.
REQ-021 The highlight source SHALL be the one-hot cursor in PLAY and CHECK, and the win mask in OVER.
REQ-022 disp_board and disp_select SHALL be shadow registers loaded from the working board and highlight source only on cycles where frame_start=1 (no tearing); when an update and frame_start coincide, the shadow SHALL capture the pre-edge value.
REQ-023 Latency: a place pulse at edge t SHALL appear in the working board at t+1, and in disp_board at the first frame_start edge after t+1.
REQ-024 turn, game_over and winner SHALL be driven directly from working registers and SHALL NOT be frame-synchronised.

Reset
REQ-025 Asserting reset SHALL immediately force: state PLAY, working board 0, cursor START_CELL, turn 0, winner 00, win mask 0, disp_board 0, disp_select 0.
REQ-026 Reset asserted mid-game or in CHECK SHALL abandon the game with no partial write, and pulses arriving during reset SHALL be lost.
REQ-027 After reset release, disp_select SHALL remain 0 until the first frame_start.

Configuration
REQ-028 Macro TTT_ALT_START_EN: when defined, a start-player register (reset 0) SHALL toggle on each new_game and supply turn for the new game; when undefined, every game SHALL start with turn=0.

Verification
REQ-029 Bench SHALL cover: reset, then place at cell 4, then frame_start -> disp_board=18'h00100, turn=1, disp_select=9'h010.
REQ-030 Bench SHALL cover: cursor at 0, then btn_left, then btn_up -> cursor at 8; after frame_start, disp_select=9'h100.
REQ-031 Bench SHALL cover: P1 at 0,1,2 with P2 at 3,4 -> winner=01 and game_over=1 two cycles after the final place; after frame_start, disp_select=9'h007; further btn_place causes no change.
REQ-032 Bench SHALL cover: a full board with no line -> winner=11, disp_select=0 after frame_start.
REQ-033 Bench SHALL cover: btn_place on an occupied cell -> board, turn and state unchanged; btn_place together with btn_up in the same cycle -> place taken, cursor unchanged.
REQ-034 Bench SHALL cover: with TTT_ALT_START_EN defined, two new_game pulses -> turn=1, then turn=0; with it undefined -> turn=0 both times.
